gpio_bus_master: RTL

Bus initiator for the single-cycle peripheral bus used by the GPIO controller (sel/we/addr/wdata out, combinational rdata back). It accepts commands over a valid/ready port, buffers them in a small FIFO, and runs each one as a bus write, a bus read, or a poll loop that repeats reads until a masked match or a retry limit. Each command produces exactly one response on a valid/ready response port. It sits between a control source (CPU shim, test sequencer, debug bridge) and any peripheral on this bus.

---
 rtl/gpio_bus_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gpio_bus_master.sv
// Command-driven initiator for the single-cycle GPIO peripheral bus: queued
// write/read/poll commands, each answered by exactly one response.
module gpio_bus_master #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_MAX   = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              o_sel,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_ILL = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, RESP} state_t;

  function automatic logic poll_match(input logic [DATA_W-1:0] sample,
                                      input logic [DATA_W-1:0] value,
                                      input logic [DATA_W-1:0] mask);
    return (sample & mask) == (value & mask);
  endfunction

  // Command FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [1:0]        fifo_op    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_mask  [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, mask_q, rdata_q;
  logic [1:0]        status_q;
  logic [CNT_W-1:0]  poll_cnt, cnt_nxt;
  logic              hit;

  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign cmd_ready = resetn && !full;
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state_q == IDLE) && !empty;
  assign busy  = (state_q != IDLE) || !empty;

  assign cnt_nxt = poll_cnt + 1'b1;
  assign hit     = poll_match(i_rdata, wdata_q, mask_q);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[PTR_W-1:0]]    <= cmd_op;
      fifo_addr[wr_ptr[PTR_W-1:0]]  <= cmd_addr;
      fifo_wdata[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
      fifo_mask[wr_ptr[PTR_W-1:0]]  <= cmd_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    o_sel      = 1'b0;
    o_we       = 1'b0;
    o_addr     = '0;
    o_wdata    = '0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    rsp_status = '0;
    case (state_q)
      IDLE: begin
        if (!empty)
          state_d = (fifo_op[rd_ptr[PTR_W-1:0]] == OP_ILL) ? RESP : ACCESS;
      end
      ACCESS: begin
        o_sel   = 1'b1;
        o_addr  = addr_q;
        o_we    = (op_q == OP_WR);
        o_wdata = (op_q == OP_WR) ? wdata_q : '0;
        if (op_q == OP_POLL && !hit && cnt_nxt != CNT_W'(POLL_MAX))
          state_d = GAP;
        else
          state_d = RESP;
      end
      GAP: state_d = ACCESS;
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = rdata_q;
        rsp_status = status_q;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers: loaded on pop, result captured at the end of ACCESS
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q     <= OP_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
      poll_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            op_q     <= fifo_op[rd_ptr[PTR_W-1:0]];
            addr_q   <= fifo_addr[rd_ptr[PTR_W-1:0]];
            wdata_q  <= fifo_wdata[rd_ptr[PTR_W-1:0]];
            mask_q   <= fifo_mask[rd_ptr[PTR_W-1:0]];
            rdata_q  <= '0;
            poll_cnt <= '0;
            status_q <= (fifo_op[rd_ptr[PTR_W-1:0]] == OP_ILL) ? ST_ILL : ST_OK;
          end
        end
        ACCESS: begin
          if (op_q == OP_RD || op_q == OP_POLL) rdata_q <= i_rdata;
          if (op_q == OP_POLL) begin
            poll_cnt <= cnt_nxt;
            if (!hit && cnt_nxt == CNT_W'(POLL_MAX)) status_q <= ST_TO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
